// File: rtl/multdiv_divider_pkg.sv
// Shared definitions for the multdiv divide path: state encoding, width and latency.
package multdiv_divider_pkg;

   localparam int DIV_WIDTH   = 32;
   localparam int DIV_LATENCY = DIV_WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/multdiv_divider_negate.sv
// Two's-complement negation (bitwise invert then add one), purely combinational.
module twos_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] negated
);

   assign negated = ~value + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/multdiv_divider.sv
// Multi-cycle signed divider: magnitude conversion, restoring shift-subtract loop,
// then quotient sign fix. Fixed latency, one quotient bit per cycle.
module multdiv_divider
   import multdiv_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy,
   output div_state_e       state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [CW-1:0]    count;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;

   logic [WIDTH-1:0] neg_a;
   logic [WIDTH-1:0] neg_b;
   logic [WIDTH-1:0] neg_quo;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted_rem;
   logic [WIDTH:0]   trial;

   twos_negate #(.WIDTH(WIDTH)) u_neg_a   (.value(data_operandA), .negated(neg_a));
   twos_negate #(.WIDTH(WIDTH)) u_neg_b   (.value(data_operandB), .negated(neg_b));
   twos_negate #(.WIDTH(WIDTH)) u_neg_quo (.value(quo),           .negated(neg_quo));

   // Magnitudes are unsigned, so the most negative operand maps to itself exactly.
   assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
   assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

   // The extra remainder bit makes the trial's MSB the borrow of the subtract.
   assign shifted_rem = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign trial       = shifted_rem - {1'b0, mag_b};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         count          <= '0;
         sign_a         <= 1'b0;
         sign_b         <= 1'b0;
         mag_b          <= '0;
         rem            <= '0;
         quo            <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else if (ctrl_DIV) begin
         // A start in any state discards whatever was in flight.
         state          <= RUN;
         count          <= '0;
         sign_a         <= data_operandA[WIDTH-1];
         sign_b         <= data_operandB[WIDTH-1];
         mag_b          <= abs_b;
         rem            <= '0;
         quo            <= abs_a;
         data_resultRDY <= 1'b0;
         busy           <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               data_resultRDY <= 1'b0;
            end
            RUN: begin
               if (!trial[WIDTH]) begin
                  rem <= trial;
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted_rem;
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               count <= count + 1'b1;
               if (count == LAST_STEP) state <= FIX;
            end
            FIX: begin
               if (mag_b == '0) begin
                  data_result    <= '0;
                  data_exception <= 1'b1;
               end else begin
                  data_result    <= (sign_a ^ sign_b) ? neg_quo : quo;
                  data_exception <= 1'b0;
               end
               data_resultRDY <= 1'b1;
               busy           <= 1'b0;
               state          <= DONE;
            end
            DONE: begin
               data_resultRDY <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_divider.sv
// Bench for multdiv_divider: directed corner cases plus random operands against
// a plain-arithmetic reference model.
module tb_multdiv_divider;
   import multdiv_divider_pkg::*;

   localparam int W = DIV_WIDTH;
   // Counting the ctrl_DIV cycle as cycle 1, RDY lands in cycle DIV_LATENCY,
   // i.e. it is first seen after the (DIV_LATENCY-1)th edge past the sampling edge.
   localparam int RDY_EDGES  = DIV_LATENCY - 1;
   localparam int BUSY_CYCLES = DIV_LATENCY - 1;
   localparam int TIMEOUT    = 100;

   logic         clock;
   logic         resetn;
   logic         ctrl_DIV;
   logic [W-1:0] data_operandA;
   logic [W-1:0] data_operandB;
   logic [W-1:0] data_result;
   logic         data_exception;
   logic         data_resultRDY;
   logic         busy;
   div_state_e   state;

   int total = 0;
   int bad   = 0;

   multdiv_divider #(.WIDTH(W)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy),
      .state          (state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference: signed division truncating toward zero, low W bits kept.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic exc);
      longint sa, sb, sq;
      if (b == '0) begin
         q   = '0;
         exc = 1'b1;
      end else begin
         sa  = longint'($signed(a));
         sb  = longint'($signed(b));
         sq  = sa / sb;
         q   = sq[W-1:0];
         exc = 1'b0;
      end
   endfunction

   // Raise ctrl_DIV now (away from an edge) and drop it just after the next edge.
   task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b);
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      start_now(a, b);
   endtask

   // Called right after the start edge; returns edges until RDY (-1 on timeout).
   task automatic wait_rdy(output int cycles, output int busy_cnt);
      bit seen;
      seen     = 0;
      cycles   = 0;
      busy_cnt = busy ? 1 : 0;
      while (!seen && cycles < TIMEOUT) begin
         @(posedge clock);
         #1;
         cycles++;
         if (data_resultRDY) seen = 1;
         else if (busy) busy_cnt++;
      end
      if (!seen) cycles = -1;
   endtask

   task automatic test_reset;
      resetn        = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if (data_result !== '0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 ||
          busy !== 1'b0 || state !== IDLE) begin
         bad++;
         $display("FAIL reset_outputs: result=%h exc=%b rdy=%b busy=%b state=%0d, required all zero/IDLE",
                  data_result, data_exception, data_resultRDY, busy, state);
      end
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_basic;
      int cycles, busy_cnt;
      start_op(32'd100, 32'd7);
      wait_rdy(cycles, busy_cnt);
      total++;
      if (cycles !== RDY_EDGES) begin
         bad++;
         $display("FAIL basic_latency: edges=%0d required=%0d", cycles, RDY_EDGES);
      end
      total++;
      if (busy_cnt !== BUSY_CYCLES) begin
         bad++;
         $display("FAIL basic_busy: busy_cycles=%0d required=%0d", busy_cnt, BUSY_CYCLES);
      end
      total++;
      if (data_result !== 32'h0000000E || data_exception !== 1'b0) begin
         bad++;
         $display("FAIL basic_result: got %h exc=%b required 0000000e exc=0", data_result, data_exception);
      end
      @(posedge clock);
      #1;
      total++;
      if (data_resultRDY !== 1'b0 || data_result !== 32'h0000000E || state !== IDLE || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_hold: rdy=%b result=%h state=%0d busy=%b required rdy=0 result=0000000e IDLE busy=0",
                  data_resultRDY, data_result, state, busy);
      end
   endtask

   task automatic test_directed;
      logic [W-1:0] a_tab [8] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd5,
                                  32'd9, 32'h80000000, 32'h7FFFFFFF, 32'd3};
      logic [W-1:0] b_tab [8] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0,
                                  32'd3, 32'hFFFFFFFF, 32'd1, 32'd10};
      logic [W-1:0] q_tab [8] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0000000E, 32'h0,
                                  32'd3, 32'h80000000, 32'h7FFFFFFF, 32'd0};
      logic         e_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int cycles, busy_cnt;
      for (int i = 0; i < 8; i++) begin
         start_op(a_tab[i], b_tab[i]);
         wait_rdy(cycles, busy_cnt);
         total++;
         if (cycles !== RDY_EDGES || data_result !== q_tab[i] || data_exception !== e_tab[i]) begin
            bad++;
            $display("FAIL directed_%0d: %h/%h edges=%0d result=%h exc=%b required edges=%0d result=%h exc=%b",
                     i, a_tab[i], b_tab[i], cycles, data_result, data_exception,
                     RDY_EDGES, q_tab[i], e_tab[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a, b, q;
      logic         e;
      int cycles, busy_cnt;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h80000000;
         case ($urandom_range(0, 4))
            0: b = $urandom_range(1, 20);
            1: b = '0;
            2: b = $urandom;
            3: b = 32'hFFFFFFFF;
            default: b = -($urandom_range(1, 1000));
         endcase
         ref_div(a, b, q, e);
         start_op(a, b);
         wait_rdy(cycles, busy_cnt);
         total++;
         if (cycles !== RDY_EDGES || data_result !== q || data_exception !== e) begin
            bad++;
            $display("FAIL random_%0d: %h/%h edges=%0d result=%h exc=%b required edges=%0d result=%h exc=%b",
                     i, a, b, cycles, data_result, data_exception, RDY_EDGES, q, e);
         end
      end
   endtask

   task automatic test_restart;
      int cycles, busy_cnt;
      start_op(32'd1000, 32'd10);
      repeat (10) @(posedge clock);
      start_op(32'd81, 32'd9);
      wait_rdy(cycles, busy_cnt);
      total++;
      if (cycles !== RDY_EDGES || data_result !== 32'd9) begin
         bad++;
         $display("FAIL restart: edges=%0d result=%h required edges=%0d result=00000009",
                  cycles, data_result, RDY_EDGES);
      end
   endtask

   task automatic test_back_to_back;
      int cycles, busy_cnt;
      start_op(32'd20, 32'd4);
      wait_rdy(cycles, busy_cnt);
      total++;
      if (cycles !== RDY_EDGES || data_result !== 32'd5) begin
         bad++;
         $display("FAIL b2b_first: edges=%0d result=%h required edges=%0d result=00000005",
                  cycles, data_result, RDY_EDGES);
      end
      // New start sampled on the edge that ends the DONE cycle.
      start_now(32'd77, 32'd7);
      total++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b1 || data_result !== 32'd5) begin
         bad++;
         $display("FAIL b2b_restart: rdy=%b busy=%b result=%h required rdy=0 busy=1 result=00000005",
                  data_resultRDY, busy, data_result);
      end
      wait_rdy(cycles, busy_cnt);
      total++;
      if (cycles !== RDY_EDGES || data_result !== 32'd11) begin
         bad++;
         $display("FAIL b2b_second: edges=%0d result=%h required edges=%0d result=0000000b",
                  cycles, data_result, RDY_EDGES);
      end
   endtask

   task automatic test_reset_mid_op;
      int cycles, busy_cnt, rdy_seen;
      start_op(32'd50, 32'd5);
      repeat (19) @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      total++;
      if (data_result !== '0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 ||
          busy !== 1'b0 || state !== IDLE) begin
         bad++;
         $display("FAIL reset_mid_op: result=%h exc=%b rdy=%b busy=%b state=%0d required all zero/IDLE",
                  data_result, data_exception, data_resultRDY, busy, state);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn   = 1'b1;
      rdy_seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (data_resultRDY || busy) rdy_seen++;
      end
      total++;
      if (rdy_seen !== 0) begin
         bad++;
         $display("FAIL reset_no_rdy: active_cycles=%0d required 0", rdy_seen);
      end
      start_op(32'd50, 32'd5);
      wait_rdy(cycles, busy_cnt);
      total++;
      if (cycles !== RDY_EDGES || data_result !== 32'd10 || data_exception !== 1'b0) begin
         bad++;
         $display("FAIL reset_recover: edges=%0d result=%h exc=%b required edges=%0d result=0000000a exc=0",
                  cycles, data_result, data_exception, RDY_EDGES);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_directed();
      test_random();
      test_restart();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
